// File: rtl/alu_exec_unit.sv
// Execute-stage unit: registered result/zero/illegal with a one-cycle done pulse.
// Define ALU_MUL_EN to build the iterative shift-add multiplier and its stall path.
module alu_exec_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             done,
  output logic             illegal,
  output logic             busy,
  output logic             stall
);

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b100,
    OP_MUL = 3'b101,
    OP_SLT = 3'b110
  } op_t;

  logic [WIDTH-1:0] single_res;
  logic             single_ill;
  logic             complete;
  logic [WIDTH-1:0] complete_res;
  logic             complete_ill;

  // Single-cycle datapath; MUL falls into the unused bucket here and is
  // intercepted by the FSM when the multiplier is built.
  always_comb begin
    single_res = '0;
    single_ill = 1'b0;
    case (alu_control)
      OP_AND:  single_res = src_a & src_b;
      OP_OR:   single_res = src_a | src_b;
      OP_ADD:  single_res = src_a + src_b;
      OP_SUB:  single_res = src_a - src_b;
      OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: single_ill = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  typedef enum logic {IDLE, MUL} state_t;

  localparam int unsigned   CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_next;
  logic [CW-1:0]    count;
  logic             is_mul, mul_load, mul_last;

  assign is_mul   = (alu_control == OP_MUL);
  assign acc_next = mplier[0] ? acc + mcand : acc;
  assign mul_last = (count == LAST);

  always_comb begin
    state_d      = state_q;
    mul_load     = 1'b0;
    complete     = 1'b0;
    complete_res = single_res;
    complete_ill = single_ill;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_mul) begin
            mul_load = 1'b1;
            state_d  = MUL;
          end else begin
            complete = 1'b1;
          end
        end
      end
      MUL: begin
        // The final add is folded into the write so the product lands at N+WIDTH.
        if (mul_last) begin
          complete     = 1'b1;
          complete_res = acc_next;
          complete_ill = 1'b0;
          state_d      = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      count   <= '0;
    end else begin
      state_q <= state_d;
      if (mul_load) begin
        mcand  <= src_a;
        mplier <= src_b;
        acc    <= '0;
        count  <= '0;
      end else if (state_q == MUL) begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + 1'b1;
      end
    end
  end

  assign busy  = (state_q == MUL);
  assign stall = busy | (start & (state_q == IDLE) & is_mul);
`else
  assign complete     = start;
  assign complete_res = single_res;
  assign complete_ill = single_ill;
  assign busy         = 1'b0;
  assign stall        = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result  <= '0;
      zero    <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      done <= 1'b0;
      if (complete) begin
        result  <= complete_res;
        zero    <= (complete_res == '0);
        illegal <= complete_ill;
        done    <= 1'b1;
      end
    end
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage unit that sits directly downstream of the ALU control decoder. It consumes the 3-bit ALU control code and two operands, and produces a registered result and zero flag. Logic and arithmetic codes complete in one cycle. MUL runs as an iterative shift-add multiplier over WIDTH cycles, and a stall output holds the PC and pipeline registers while it runs.

## Interface
- WIDTH, 32, operand/result width in bits (≥4)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  operation request; sampled only in IDLE
- alu_control  input  3  000 AND, 001 OR, 010 ADD, 100 SUB, 101 MUL, 110 SLT, 011/111 unused
- src_a  input  WIDTH  operand A
- src_b  input  WIDTH  operand B
- result  output  WIDTH  registered result; holds its value until the next completion
- zero  output  1  registered; (result == 0), updated together with result
- done  output  1  one-cycle pulse when result/zero update
- illegal  output  1  registered; 1 if the completed op was an unused code
- busy  output  1  high while in MUL state
- stall  output  1  combinational: busy | (start & IDLE & alu_control==101)

## Operation
- States: IDLE, MUL. Reset state IDLE.
- IDLE, start=0: nothing changes; done=0.
- IDLE, start=1, single-cycle code: at the clock edge, result, zero and illegal=0 are written and done=1 for the following cycle. The unit stays in IDLE.
  - AND, OR: bitwise.
  - ADD, SUB: modulo 2^WIDTH, no overflow flag.
  - SLT: signed compare; result = {0…,1} if $signed(a) < $signed(b), else 0.
- IDLE, start=1, unused code: result=0, zero=1, illegal=1, done pulse; latency 1.
- IDLE, start=1, MUL:
  - Latch multiplicand=src_a, multiplier=src_b, acc=0, count=0. Go to MUL.
  - Each MUL cycle: if multiplier[0], acc += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, count++.
  - Only the low WIDTH bits of acc are kept, so the product is the unsigned/two's-complement low word.
  - On the iteration where count == WIDTH-1: write result = final acc, zero, illegal=0; done=1 next cycle; return to IDLE.
- start while busy: ignored and not queued. Operands and alu_control may change freely during MUL.
- result/zero/illegal hold between completions.

## Timing
- Reset (async, any state, including mid-MUL): state=IDLE, result=0, zero=0, done=0, illegal=0, busy=0, internal acc/count=0. An aborted MUL produces no done.
- Single-cycle op: start at edge N → result/done valid in the cycle after edge N (latency 1). Back-to-back starts give one done per cycle.
- MUL: start sampled at edge N.
  - busy=1 after edges N … N+WIDTH-1.
  - Result written at edge N+WIDTH; done=1 and busy=0 in the cycle after that edge (latency WIDTH).
- The done cycle is IDLE, so a start in the done cycle is accepted. No dead cycle.
- stall rises combinationally in the request cycle and stays high through the last busy cycle. It is low in the done cycle.

## Configuration
- ALU_MUL_EN defined: MUL state, iterative datapath and stall-on-MUL are present, as described above.
- ALU_MUL_EN undefined:
  - Code 101 is treated as unused (result=0, zero=1, illegal=1, latency 1).
  - busy is tied 0 and stall is tied 0.
  - No MUL state and no accumulator are synthesized.

## Test plan
- Reset mid-MUL: start MUL 7×9 (WIDTH=32), assert reset at cycle 5 → all outputs 0 immediately, no done; then ADD 1+1 → result=2, done next cycle.
- Single-cycle ops: AND 0xF0F0_F0F0&0x0FF0_0FF0 → 0x00F0_00F0; OR → 0xFFF0_FFF0; SUB 5-5 → 0, zero=1; ADD 0xFFFF_FFFF+1 → 0, zero=1.
- SLT signed: a=0xFFFF_FFFF (-1), b=1 → result 1; a=1, b=0xFFFF_FFFF → result 0, zero=1.
- MUL latency/handshake: 0x0001_0003×0x0002_0005 → result 0x000B_000F, done exactly 32 cycles after start edge, busy high 32 cycles. A start pulse with ADD mid-MUL is ignored. A new ADD in the done cycle completes the next cycle.
- MUL wrap/signed: 0xFFFF_FFFF×0xFFFF_FFFF → 0x0000_0001. 0x8000_0000×2 → 0, zero=1.
- Unused code 011 → result 0, illegal=1, done latency 1. With ALU_MUL_EN undefined, 101 behaves the same and stall stays 0.
